tick_scheduler: RTL and testbench

- Central timing controller. Replaces free-running divided clocks with single-cycle clock-enable strobes on the 100 MHz master clock.
- Outputs:
  - pixel strobe at 25 MHz
  - 7-segment scan strobe with digit select
  - game-logic tick with a runtime-programmable rate, pause and single-step
- Sits at top level; VGA, display-mux and game FSM blocks all run on clk and are gated by these strobes.

---
 rtl/tick_pkg.sv | 18 +
 rtl/tick_gen.sv | 35 +++
 rtl/tick_scheduler.sv | 153 +++++++++++++++
 tb/tb_tick_scheduler.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/tick_pkg.sv
// Shared types and default rates for the master-clock tick scheduler.
// Every strobe is a one-cycle clock enable on the 100 MHz clock.
package tick_pkg;

   localparam int CLK_HZ           = 100_000_000;
   localparam int PIX_DIV_DEF      = 4;
   localparam int SEG_DIV_DEF      = 262_144;
   localparam int GAME_DIV_W_DEF   = 24;
   localparam int GAME_DIV_RST_DEF = CLK_HZ / 50;
   localparam int FRAME_W_DEF      = 16;

   typedef enum logic [1:0] {
      RUN,
      PAUSED,
      STEP
   } state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running modulo-DIV counter with a registered one-cycle strobe.
// wrap_o marks the edge that will raise tick_o, so other state can advance with it.
module tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk_i,
   input  logic clr_i,
   output logic wrap_o,
   output logic tick_o
);

   localparam int            CW   = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q;

   assign wrap_o = (cnt_q == LAST);
   assign tick_o = tick_q;

   always_comb begin
      cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk_i or posedge clr_i) begin
      if (clr_i) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= wrap_o;
      end
   end

endmodule

// File: rtl/tick_scheduler.sv
// Central timing controller: pixel and segment-scan strobes plus a pausable,
// single-steppable game tick whose rate is reprogrammed through a shadow register.
module tick_scheduler
   import tick_pkg::*;
#(
   parameter int PIX_DIV      = PIX_DIV_DEF,
   parameter int SEG_DIV      = SEG_DIV_DEF,
   parameter int GAME_DIV_W   = GAME_DIV_W_DEF,
   parameter int GAME_DIV_RST = GAME_DIV_RST_DEF,
   parameter int FRAME_W      = FRAME_W_DEF
) (
   input  logic                  clk,
   input  logic                  clr,
   output logic                  pix_tick,
   output logic                  seg_tick,
   output logic [1:0]            seg_sel,
   output logic                  game_tick,
   output logic [FRAME_W-1:0]    frame_cnt,
   input  logic                  pause,
   input  logic                  step,
   output logic                  running,
   input  logic                  cfg_valid,
   input  logic [GAME_DIV_W-1:0] cfg_div,
   output logic                  cfg_ready
);

   localparam int W = GAME_DIV_W;

   function automatic logic [W-1:0] clamp_div(input logic [W-1:0] d);
      return (d < W'(2)) ? W'(2) : d;
   endfunction

   logic pix_wrap_unused;
   logic seg_wrap;

   tick_gen #(.DIV(PIX_DIV)) u_pix (
      .clk_i  (clk),
      .clr_i  (clr),
      .wrap_o (pix_wrap_unused),
      .tick_o (pix_tick)
   );

   tick_gen #(.DIV(SEG_DIV)) u_seg (
      .clk_i  (clk),
      .clr_i  (clr),
      .wrap_o (seg_wrap),
      .tick_o (seg_tick)
   );

   state_e               state_q, state_d;
   logic [W-1:0]         g_cnt_q, g_cnt_d;
   logic [W-1:0]         div_q, div_d;
   logic [W-1:0]         shadow_q, shadow_d;
   logic                 shadow_vld_q, shadow_vld_d;
   logic                 game_tick_q, game_tick_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic                 step_q;
   logic [1:0]           seg_sel_q;
   logic                 step_edge;

   assign step_edge = step & ~step_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= RUN;
         g_cnt_q      <= '0;
         div_q        <= W'(GAME_DIV_RST);
         shadow_q     <= '0;
         shadow_vld_q <= 1'b0;
         game_tick_q  <= 1'b0;
         frame_q      <= '0;
         step_q       <= 1'b0;
         seg_sel_q    <= 2'd0;
      end else begin
         state_q      <= state_d;
         g_cnt_q      <= g_cnt_d;
         div_q        <= div_d;
         shadow_q     <= shadow_d;
         shadow_vld_q <= shadow_vld_d;
         game_tick_q  <= game_tick_d;
         frame_q      <= frame_d;
         step_q       <= step;
         if (seg_wrap) seg_sel_q <= seg_sel_q + 2'd1;
      end
   end

   // A step edge arriving together with pause release is dropped in favour of RUN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (pause) state_d = PAUSED;
         PAUSED:  if (!pause) state_d = RUN;
                  else if (step_edge) state_d = STEP;
         STEP:    if (!pause) state_d = RUN;
                  else if (!step) state_d = PAUSED;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      g_cnt_d      = g_cnt_q;
      div_d        = div_q;
      shadow_d     = shadow_q;
      shadow_vld_d = shadow_vld_q;
      game_tick_d  = 1'b0;
      frame_d      = frame_q;
      unique case (state_q)
         RUN: begin
            if (!pause) begin
               if (g_cnt_q == div_q - W'(1)) begin
                  g_cnt_d     = '0;
                  game_tick_d = 1'b1;
                  frame_d     = frame_q + FRAME_W'(1);
                  if (shadow_vld_q) begin
                     div_d        = shadow_q;
                     shadow_vld_d = 1'b0;
                  end
               end else begin
                  g_cnt_d = g_cnt_q + W'(1);
               end
            end
         end
         PAUSED: begin
            if (pause && step_edge) begin
               g_cnt_d     = '0;
               game_tick_d = 1'b1;
               frame_d     = frame_q + FRAME_W'(1);
            end
         end
         STEP: begin
            if (!pause) g_cnt_d = '0;
         end
         default: ;
      endcase
      // Outside RUN there is no period to protect, so a pending divisor lands at once.
      if (state_q != RUN && shadow_vld_q) begin
         div_d        = shadow_q;
         g_cnt_d      = '0;
         shadow_vld_d = 1'b0;
      end
      if (cfg_valid && !shadow_vld_q) begin
         shadow_d     = clamp_div(cfg_div);
         shadow_vld_d = 1'b1;
      end
   end

   assign game_tick = game_tick_q;
   assign frame_cnt = frame_q;
   assign seg_sel   = seg_sel_q;
   assign running   = (state_q == RUN);
   assign cfg_ready = ~shadow_vld_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: expected game ticks are queued by the
// stimulus and retired by a negedge monitor; pix/seg strobes are checked every cycle.
module tb_tick_scheduler;

   localparam int PIX  = 4;
   localparam int SEG  = 8;
   localparam int GRST = 10;
   localparam int GW   = 24;
   localparam int FW   = 16;

   logic          clk = 1'b0;
   logic          clr = 1'b1;
   logic          pix_tick, seg_tick, game_tick, running, cfg_ready;
   logic [1:0]    seg_sel;
   logic [FW-1:0] frame_cnt;
   logic          pause = 1'b0;
   logic          step = 1'b0;
   logic          cfg_valid = 1'b0;
   logic [GW-1:0] cfg_div = '0;

   int checks = 0;
   int errors = 0;
   int cyc;

   typedef struct {
      int edg;
      int frm;
   } exp_t;
   exp_t q[$];
   exp_t mon_e;

   tick_scheduler #(
      .PIX_DIV(PIX), .SEG_DIV(SEG), .GAME_DIV_W(GW),
      .GAME_DIV_RST(GRST), .FRAME_W(FW)
   ) dut (
      .clk(clk), .clr(clr), .pix_tick(pix_tick), .seg_tick(seg_tick),
      .seg_sel(seg_sel), .game_tick(game_tick), .frame_cnt(frame_cnt),
      .pause(pause), .step(step), .running(running),
      .cfg_valid(cfg_valid), .cfg_div(cfg_div), .cfg_ready(cfg_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge clr) begin
      if (clr) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at edge %0d: actual=%0d required=%0d", name, cyc, act, req);
      end
   endtask

   always @(negedge clk) begin
      chk("pix_tick", int'(pix_tick), int'(cyc > 0 && cyc % PIX == 0));
      chk("seg_tick", int'(seg_tick), int'(cyc > 0 && cyc % SEG == 0));
      chk("seg_sel", int'(seg_sel), (cyc / SEG) % 4);
      if (game_tick) begin
         if (q.size() == 0) begin
            chk("game_tick_unexpected", 1, 0);
         end else begin
            mon_e = q.pop_front();
            chk("game_tick_edge", cyc, mon_e.edg);
            chk("game_frame_cnt", int'(frame_cnt), mon_e.frm);
         end
      end
   end

   task automatic wait_to(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pix_tick"}, int'(pix_tick), 0);
      chk({tag, "_seg_tick"}, int'(seg_tick), 0);
      chk({tag, "_seg_sel"}, int'(seg_sel), 0);
      chk({tag, "_game_tick"}, int'(game_tick), 0);
      chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
      chk({tag, "_running"}, int'(running), 1);
      chk({tag, "_cfg_ready"}, int'(cfg_ready), 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr = 1'b1;
      #1 chk_reset("rst");
      @(negedge clk);
      clr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Power-on reset, free-running strobes and default-rate game ticks
      #1 chk_reset("por");
      @(negedge clk);
      clr = 1'b0;
      q.push_back('{10, 1});
      q.push_back('{20, 2});
      q.push_back('{30, 3});
      wait_to(5);
      chk("run_running", int'(running), 1);
      wait_to(35);
      chk("run_frame_cnt", int'(frame_cnt), 3);
      chk("run_running_end", int'(running), 1);
      chk("run_queue_empty", q.size(), 0);

      // Pause mid-period, resume, then single-step while paused
      do_reset();
      q.push_back('{31, 1});
      q.push_back('{37, 2});
      q.push_back('{41, 3});
      q.push_back('{45, 4});
      q.push_back('{51, 5});
      q.push_back('{73, 6});
      wait_to(4);  pause = 1'b1;
      wait_to(10);
      chk("paused_running", int'(running), 0);
      wait_to(24); pause = 1'b0;
      wait_to(26);
      chk("resumed_running", int'(running), 1);
      wait_to(33); pause = 1'b1;
      wait_to(36); step = 1'b1;
      wait_to(38); step = 1'b0;
      wait_to(40); step = 1'b1;
      wait_to(42); step = 1'b0;
      wait_to(44); step = 1'b1;
      wait_to(46); step = 1'b0;
      wait_to(50); step = 1'b1;
      wait_to(60); step = 1'b0;
      wait_to(62);
      chk("step_running", int'(running), 0);
      chk("step_frame_cnt", int'(frame_cnt), 5);
      pause = 1'b0;
      wait_to(75);
      chk("step_frame_end", int'(frame_cnt), 6);
      chk("step_queue_empty", q.size(), 0);

      // Divisor reprogramming: applied only at the tick edge while running
      do_reset();
      q.push_back('{10, 1});
      q.push_back('{14, 2});
      q.push_back('{18, 3});
      q.push_back('{22, 4});
      q.push_back('{24, 5});
      q.push_back('{26, 6});
      q.push_back('{28, 7});
      wait_to(2);  cfg_valid = 1'b1; cfg_div = GW'(4);
      wait_to(3);  cfg_valid = 1'b0;
      chk("cfg_ready_after_accept", int'(cfg_ready), 0);
      wait_to(9);
      chk("cfg_ready_before_apply", int'(cfg_ready), 0);
      wait_to(10);
      chk("cfg_ready_after_apply", int'(cfg_ready), 1);
      wait_to(18); cfg_valid = 1'b1; cfg_div = '0;
      wait_to(19); cfg_valid = 1'b0;
      chk("cfg_ready_clamp_accept", int'(cfg_ready), 0);
      wait_to(22);
      chk("cfg_ready_clamp_apply", int'(cfg_ready), 1);

      // Async clear with a divisor still pending in the shadow
      wait_to(27); cfg_valid = 1'b1; cfg_div = GW'(7);
      wait_to(28); cfg_valid = 1'b0;
      chk("cfg_ready_pending", int'(cfg_ready), 0);
      #2;
      chk("cfg_queue_empty", q.size(), 0);
      clr = 1'b1;
      #1 chk_reset("async");
      @(negedge clk);
      clr = 1'b0;
      q.push_back('{10, 1});
      wait_to(12);
      chk("post_clr_cfg_ready", int'(cfg_ready), 1);
      chk("post_clr_frame_cnt", int'(frame_cnt), 1);
      chk("post_clr_queue_empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
